// File: rtl/input_arbiter.sv
// Key-event arbiter: press pulses plus tick-based auto-repeat, merged per button
// and serialised round-robin onto one valid/ready command stream.
module input_arbiter #(
    parameter int               N_REQ        = 5,
    parameter int               ID_W         = 3,
    parameter logic [N_REQ-1:0] REPEAT_EN    = 5'b01011,
    parameter int               REPEAT_DELAY = 24,
    parameter int               REPEAT_RATE  = 6,
    parameter int               CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] press,
    input  logic [N_REQ-1:0] held,
    input  logic             tick,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [ID_W-1:0]  cmd_id,
    output logic             cmd_repeat,
    output logic             overrun
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] pending, pending_nxt;
    logic [N_REQ-1:0] rep, rep_nxt;
    logic [N_REQ-1:0] fire, set, clr;
    logic [CNT_W-1:0] cnt     [N_REQ];
    logic [CNT_W-1:0] cnt_nxt [N_REQ];
    logic [ID_W-1:0]  last, last_nxt;
    logic [ID_W-1:0]  grant, id_nxt;
    logic             found, repeat_nxt, overrun_nxt;

    always_comb begin
        fire = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_nxt[i] = cnt[i];
            if (!REPEAT_EN[i] || !held[i] || press[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (cnt[i] == CNT_W'(REPEAT_DELAY - 1)) begin
                    fire[i]    = 1'b1;
                    cnt_nxt[i] = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Round-robin search starts just after the last granted button.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && pending[(int'(last) + k) % N_REQ]) begin
                found = 1'b1;
                grant = ID_W'((int'(last) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        id_nxt     = cmd_id;
        repeat_nxt = cmd_repeat;
        last_nxt   = last;
        clr        = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt  = OFFER;
                    id_nxt     = grant;
                    repeat_nxt = rep[grant];
                    last_nxt   = grant;
                    for (int i = 0; i < N_REQ; i++)
                        clr[i] = (grant == ID_W'(i));
                end
            end
            OFFER: begin
                if (cmd_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        set         = press | fire;
        pending_nxt = set | (pending & ~clr);
        rep_nxt     = (rep & ~press) | fire;
        overrun_nxt = |(set & pending & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            rep        <= '0;
            last       <= ID_W'(N_REQ - 1);
            cmd_id     <= '0;
            cmd_repeat <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < N_REQ; i++)
                cnt[i] <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            rep        <= rep_nxt;
            last       <= last_nxt;
            cmd_id     <= id_nxt;
            cmd_repeat <= repeat_nxt;
            overrun    <= overrun_nxt;
            for (int i = 0; i < N_REQ; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end

    assign cmd_valid = (state == OFFER);

endmodule

// File: tb/tb_input_arbiter.sv
// Bench for input_arbiter: behavioural model compared every cycle, directed
// scenarios with literal expectations, then a randomised soak.
module tb_input_arbiter;

    localparam int N     = 5;
    localparam int DELAY = 24;
    localparam int RATE  = 6;
    localparam logic [N-1:0] EN = 5'b01011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] press = '0;
    logic [N-1:0] held = '0;
    logic         tick = 1'b0;
    logic         cmd_ready = 1'b0;
    logic         cmd_valid;
    logic [2:0]   cmd_id;
    logic         cmd_repeat;
    logic         overrun;

    input_arbiter dut (
        .clk(clk), .rst(rst), .press(press), .held(held), .tick(tick),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
        .cmd_repeat(cmd_repeat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model state: held-tick counts are unbounded, repeats follow from arithmetic.
    bit           m_init = 0;
    bit [N-1:0]   m_pend, m_rep;
    int           m_ticks [N];
    bit           m_valid, m_repf, m_over;
    int           m_id, m_last;
    bit [N-1:0]   fire_m, set_m, clr_m;
    int           gidx, t;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_pend = '0; m_rep = '0; m_valid = 0;
            m_repf = 0; m_over = 0; m_id = 0; m_last = N - 1;
            for (int i = 0; i < N; i++) m_ticks[i] = 0;
        end else begin
            fire_m = '0;
            for (int i = 0; i < N; i++) begin
                if (!held[i] || press[i]) m_ticks[i] = 0;
                else if (tick) begin
                    t = m_ticks[i] + 1;
                    m_ticks[i] = t;
                    if (EN[i] && t >= DELAY && (t - DELAY) % RATE == 0)
                        fire_m[i] = 1;
                end
            end
            gidx = -1;
            if (!m_valid)
                for (int k = 1; k <= N; k++)
                    if (gidx < 0 && m_pend[(m_last + k) % N]) gidx = (m_last + k) % N;
            set_m = press | fire_m;
            clr_m = '0;
            if (gidx >= 0) clr_m[gidx] = 1;
            m_over = |(set_m & m_pend & ~clr_m);
            if (m_valid && cmd_ready) m_valid = 0;
            else if (gidx >= 0) begin
                m_valid = 1; m_id = gidx; m_repf = m_rep[gidx]; m_last = gidx;
            end
            m_rep  = (m_rep & ~press) | fire_m;
            m_pend = set_m | (m_pend & ~clr_m);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("valid", cmd_valid, m_valid);
            check("overrun", overrun, m_over);
            if (m_valid) begin
                check("id", cmd_id, m_id);
                check("repeat", cmd_repeat, m_repf);
            end
        end
    end

    task automatic do_reset();
        rst = 1; press = '0; held = '0; tick = 0; cmd_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_valid(input string nm, input int max);
        int n = 0;
        while (!cmd_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check(nm, cmd_valid, 1);
    endtask

    int q[$];
    int e2[3] = '{0, 1, 4};
    int e4[3] = '{24, 30, 36};
    int ovc, bad, tc, cnt_cmd, cnt_rep;

    initial begin
        do_reset();
        check("rst_valid", cmd_valid, 0);
        check("rst_id", cmd_id, 0);
        check("rst_repeat", cmd_repeat, 0);
        check("rst_overrun", overrun, 0);

        // single press latency
        cmd_ready = 1; press = 5'b00001;
        @(negedge clk); press = '0;
        check("t1_early", cmd_valid, 0);
        @(negedge clk);
        check("t1_valid", cmd_valid, 1);
        check("t1_id", cmd_id, 0);
        check("t1_rep", cmd_repeat, 0);
        @(negedge clk);
        check("t1_after", cmd_valid, 0);

        // simultaneous presses, round-robin order
        do_reset();
        cmd_ready = 1; press = 5'b10011;
        @(negedge clk); press = '0;
        q.delete(); ovc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (cmd_valid) q.push_back(int'(cmd_id));
            if (overrun) ovc++;
        end
        check("t2_count", q.size(), 3);
        for (int k = 0; k < 3; k++)
            check("t2_order", q.size() > k ? q[k] : -1, e2[k]);
        check("t2_overrun", ovc, 0);

        // merge while offered
        do_reset();
        press = 5'b00010;
        @(negedge clk); press = '0;
        wait_valid("t3_wait", 10);
        ovc = 0; bad = 0;
        for (int c = 0; c < 7; c++) begin
            press = (c == 0 || c == 3) ? 5'b00010 : 5'b00000;
            @(negedge clk);
            if (overrun) ovc++;
            if (!cmd_valid || cmd_id != 3'd1) bad++;
        end
        check("t3_overrun", ovc, 1);
        check("t3_stable", bad, 0);
        cmd_ready = 1;
        @(negedge clk); cmd_ready = 0;
        check("t3_bubble", cmd_valid, 0);
        @(negedge clk);
        check("t3_reoffer", cmd_valid, 1);
        check("t3_reid", cmd_id, 1);

        // auto-repeat on button 0
        do_reset();
        cmd_ready = 1; press = 5'b00001; held = 5'b00001;
        @(negedge clk); press = '0;
        q.delete(); tc = 0;
        for (int c = 0; c < 160; c++) begin
            tick = (c % 4 == 0);
            if (tick) tc++;
            @(negedge clk);
            if (cmd_valid && cmd_repeat) q.push_back(tc);
        end
        tick = 0;
        check("t4_count", q.size(), 3);
        for (int k = 0; k < 3; k++)
            check("t4_tick", q.size() > k ? q[k] : -1, e4[k]);
        held = '0; cnt_rep = 0;
        for (int c = 0; c < 120; c++) begin
            tick = (c % 4 == 0);
            @(negedge clk);
            if (cmd_valid) cnt_rep++;
        end
        tick = 0;
        check("t4_released", cnt_rep, 0);

        // rotate never repeats
        do_reset();
        cmd_ready = 1; press = 5'b00100; held = 5'b00100;
        @(negedge clk); press = '0;
        cnt_cmd = 0; cnt_rep = 0;
        for (int c = 0; c < 200; c++) begin
            tick = (c % 2 == 0);
            @(negedge clk);
            if (cmd_valid) cnt_cmd++;
            if (cmd_valid && cmd_repeat) cnt_rep++;
        end
        tick = 0; held = '0;
        check("t5_cmds", cnt_cmd, 1);
        check("t5_reps", cnt_rep, 0);

        // reset while offering with pending events
        do_reset();
        press = 5'b00001;
        @(negedge clk); press = '0;
        wait_valid("t6_wait", 10);
        press = 5'b01100;
        @(negedge clk); press = '0;
        @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0;
        check("t6_valid", cmd_valid, 0);
        check("t6_overrun", overrun, 0);
        cnt_cmd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cmd_valid) cnt_cmd++;
        end
        check("t6_quiet", cnt_cmd, 0);
        cmd_ready = 1; press = 5'b01000;
        @(negedge clk); press = '0;
        @(negedge clk);
        check("t6_new_valid", cmd_valid, 1);
        check("t6_new_id", cmd_id, 3);

        // randomised soak, model checks every cycle
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                press[i] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 199) == 0) held[i] = ~held[i];
            end
            tick      = ($urandom_range(0, 1) == 0);
            cmd_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        rst = 0; press = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
